// File: rtl/pdm_sample_sequencer.sv
// pdm_sample_sequencer: replays a small table of samples into the load port
// of a first-order PDM modulator. Each sample gets one single-cycle write
// strobe, and strobes are a programmable number of cycles apart.
//
// Optional build macro: PDM_SEQ_MUTE_EN. When it is defined, stopping
// playback issues one final zero sample, so the modulator output idles low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | table may be loaded or cleared; start begins playback
// PLAY    | strobe one sample every hold_reg+1 cycles, wrapping at count
// MUTE    | (PDM_SEQ_MUTE_EN only) one cycle that writes a zero sample
module pdm_sample_sequencer #(
    parameter int DEPTH    = 4,
    parameter int SAMPLE_W = 5,
    parameter int HOLD_W   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [SAMPLE_W-1:0] load_data_i,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [HOLD_W-1:0]   hold_period_i,
    output logic [SAMPLE_W-1:0] pdm_input_o,
    output logic                write_en_o,
    output logic                busy_o,
    output logic                full_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
`ifdef PDM_SEQ_MUTE_EN
    localparam logic [1:0] ST_MUTE = 2'd2;
`endif

    logic [1:0]          state_q,    state_d;
    logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [HOLD_W-1:0]   hold_reg_q, hold_reg_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SAMPLE_W-1:0] pdm_q,      pdm_d;
    logic                we_q,       we_d;
    logic                busy_q,     busy_d;
    logic                full_q,     full_d;

    logic [SAMPLE_W-1:0] slot_q [DEPTH];
    logic                tbl_we;
    logic [CNT_W-1:0]    rd_inc;
    logic [PTR_W-1:0]    rd_next;

    // Next playback index, wrapping at the number of loaded samples so unloaded slots are skipped.
    always_comb begin
        rd_inc  = {1'b0, rd_ptr_q} + CNT_W'(1);
        rd_next = (rd_inc == count_q) ? '0 : rd_inc[PTR_W-1:0];
    end

    // State transitions, table bookkeeping and the next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        hold_reg_d = hold_reg_q;
        hold_cnt_d = hold_cnt_q;
        pdm_d      = pdm_q;
        we_d       = 1'b0;
        tbl_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Clear wins over load, and load wins over start.
                if (clear_i) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else if (load_i) begin
                    if (count_q != CNT_W'(DEPTH)) begin
                        tbl_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        count_d  = count_q + CNT_W'(1);
                    end
                end else if (start_i && (count_q != '0)) begin
                    state_d    = ST_PLAY;
                    rd_ptr_d   = '0;
                    hold_reg_d = hold_period_i;
                    hold_cnt_d = hold_period_i;
                    we_d       = 1'b1;
                    pdm_d      = slot_q[0];
                end
            end
            ST_PLAY: begin
                // Stop wins over a strobe that is due in the same cycle.
                if (stop_i) begin
`ifdef PDM_SEQ_MUTE_EN
                    state_d = ST_MUTE;
                    we_d    = 1'b1;
                    pdm_d   = '0;
`else
                    state_d = ST_IDLE;
`endif
                end else if (hold_cnt_q == '0) begin
                    we_d       = 1'b1;
                    pdm_d      = slot_q[rd_next];
                    rd_ptr_d   = rd_next;
                    hold_cnt_d = hold_reg_q;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
`ifdef PDM_SEQ_MUTE_EN
            ST_MUTE: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Control and output registers; reset aborts playback at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            hold_reg_q <= '0;
            hold_cnt_q <= '0;
            pdm_q      <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            hold_reg_q <= hold_reg_d;
            hold_cnt_q <= hold_cnt_d;
            pdm_q      <= pdm_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
        end
    end

    // Sample table storage. It is not reset: clear only rewinds the write pointer.
    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            slot_q[wr_ptr_q] <= load_data_i;
        end
    end

    assign pdm_input_o = pdm_q;
    assign write_en_o  = we_q;
    assign busy_o      = busy_q;
    assign full_o      = full_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// Bench for pdm_sample_sequencer. It checks the design against a reference
// model: a sample table plus a count, with the expected strobe timing
// computed arithmetically from the cycle number since start.
module tb_pdm_sample_sequencer;

    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       load_i, clear_i, start_i, stop_i;
    logic [4:0] load_data_i;
    logic [3:0] hold_period_i;
    logic [4:0] pdm_input_o;
    logic       write_en_o, busy_o, full_o;
    logic [2:0] count_o;

    int errors = 0;
    int checks = 0;

    logic [4:0] tbl [DEPTH];
    int         cnt = 0;

    pdm_sample_sequencer dut (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load_i), .load_data_i(load_data_i),
        .clear_i(clear_i), .start_i(start_i), .stop_i(stop_i), .hold_period_i(hold_period_i),
        .pdm_input_o(pdm_input_o), .write_en_o(write_en_o), .busy_o(busy_o),
        .full_o(full_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ld(input logic [4:0] d);
        load_i = 1'b1; load_data_i = d;
        step();
        load_i = 1'b0;
        if (cnt < DEPTH) begin
            tbl[cnt] = d;
            cnt++;
        end
    endtask

    task automatic clr();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        cnt = 0;
    endtask

    // Start playback, then follow n cycles; k counts cycles after the start edge.
    task automatic play(input int h, input int n, input bit noise, output logic [4:0] last);
        logic exp_we;
        hold_period_i = 4'(h);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        last = 5'h00;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) begin
                if (noise) begin
                    load_i = 1'($urandom); clear_i = 1'($urandom); start_i = 1'($urandom);
                    load_data_i = 5'($urandom); hold_period_i = 4'($urandom);
                end
                step();
            end
            exp_we = ((k - 1) % (h + 1)) == 0;
            if (exp_we) last = tbl[((k - 1) / (h + 1)) % cnt];
            checks++;
            if (write_en_o !== exp_we) begin
                errors++; $display("FAIL play_we k=%0d h=%0d: got %b expected %b", k, h, write_en_o, exp_we);
            end
            checks++;
            if (pdm_input_o !== last) begin
                errors++; $display("FAIL play_pdm k=%0d h=%0d: got %h expected %h", k, h, pdm_input_o, last);
            end
            checks++;
            if (busy_o !== 1'b1) begin
                errors++; $display("FAIL play_busy k=%0d: got %b expected 1", k, busy_o);
            end
        end
        load_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic do_stop(input logic [4:0] last);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
`ifdef PDM_SEQ_MUTE_EN
        checks++;
        if (write_en_o !== 1'b1 || pdm_input_o !== 5'h00 || busy_o !== 1'b1) begin
            errors++; $display("FAIL mute_cycle: got we=%b pdm=%h busy=%b expected we=1 pdm=00 busy=1", write_en_o, pdm_input_o, busy_o);
        end
        step();
        last = 5'h00;
`endif
        checks++;
        if (write_en_o !== 1'b0 || busy_o !== 1'b0 || pdm_input_o !== last) begin
            errors++; $display("FAIL stop_out: got we=%b busy=%b pdm=%h expected we=0 busy=0 pdm=%h", write_en_o, busy_o, pdm_input_o, last);
        end
        step();
        checks++;
        if (write_en_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 3'(cnt)) begin
            errors++; $display("FAIL stop_idle: got we=%b busy=%b count=%0d expected we=0 busy=0 count=%0d", write_en_o, busy_o, count_o, cnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({pdm_input_o, write_en_o, busy_o, full_o, count_o} !== 11'd0) begin
            errors++; $display("FAIL reset_vals: got pdm=%h we=%b busy=%b full=%b count=%0d expected all 0", pdm_input_o, write_en_o, busy_o, full_o, count_o);
        end
    endtask

    task automatic test_load_fill();
        logic [4:0] vals [5];
        int exp_cnt [5];
        vals = '{5'h03, 5'h1F, 5'h10, 5'h01, 5'h07};
        exp_cnt = '{1, 2, 3, 4, 4};
        for (int i = 0; i < 5; i++) begin
            ld(vals[i]);
            checks++;
            if (count_o !== 3'(exp_cnt[i]) || full_o !== (exp_cnt[i] == DEPTH)) begin
                errors++; $display("FAIL load_fill[%0d]: got count=%0d full=%b expected count=%0d full=%b", i, count_o, full_o, exp_cnt[i], exp_cnt[i] == DEPTH);
            end
        end
    endtask

    task automatic test_playback();
        logic [4:0] last;
        clr();
        ld(5'h03); ld(5'h1F); ld(5'h10);
        play(2, 10, 1'b1, last);
        checks++;
        if (last !== 5'h03) begin
            errors++; $display("FAIL playback_wrap: got %h expected 03", last);
        end
        do_stop(last);
    endtask

    task automatic test_hold_zero();
        logic [4:0] last;
        clr();
        ld(5'h0A); ld(5'h15);
        play(0, 7, 1'b0, last);
        do_stop(last);
    endtask

    task automatic test_stop_due();
        logic [4:0] last;
        clr();
        ld(5'h11); ld(5'h05); ld(5'h1C);
        play(1, 4, 1'b1, last);
        do_stop(last);
    endtask

    task automatic test_priority();
        clr();
        ld(5'h02); ld(5'h04);
        load_i = 1'b1; clear_i = 1'b1; load_data_i = 5'h09;
        step();
        load_i = 1'b0; clear_i = 1'b0; cnt = 0;
        checks++;
        if (count_o !== 3'd0) begin
            errors++; $display("FAIL load_clear: got count=%0d expected 0", count_o);
        end
        load_i = 1'b1; start_i = 1'b1; load_data_i = 5'h0B;
        step();
        load_i = 1'b0; start_i = 1'b0; tbl[0] = 5'h0B; cnt = 1;
        checks++;
        if (count_o !== 3'd1 || busy_o !== 1'b0 || write_en_o !== 1'b0) begin
            errors++; $display("FAIL load_start: got count=%0d busy=%b we=%b expected 1 0 0", count_o, busy_o, write_en_o);
        end
        clr();
        start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy_o !== 1'b0 || write_en_o !== 1'b0) begin
                errors++; $display("FAIL start_empty[%0d]: got busy=%b we=%b expected 0 0", i, busy_o, write_en_o);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] last;
        for (int it = 0; it < 6; it++) begin
            int nl, h, n;
            clr();
            nl = $urandom_range(1, DEPTH + 1);
            for (int j = 0; j < nl; j++) ld(5'($urandom));
            checks++;
            if (count_o !== 3'(cnt) || full_o !== (cnt == DEPTH)) begin
                errors++; $display("FAIL rand_count it=%0d: got count=%0d full=%b expected %0d %b", it, count_o, full_o, cnt, cnt == DEPTH);
            end
            h = $urandom_range(0, 15);
            n = $urandom_range(1, 40);
            play(h, n, 1'b1, last);
            do_stop(last);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] last;
        clr();
        ld(5'h13); ld(5'h0E); ld(5'h1B);
        play(2, 5, 1'b0, last);
        @(posedge clk_i);
        #3 reset_i = 1'b1;
        #1;
        cnt = 0;
        checks++;
        if ({pdm_input_o, write_en_o, busy_o, full_o, count_o} !== 11'd0) begin
            errors++; $display("FAIL async_reset: got pdm=%h we=%b busy=%b full=%b count=%0d expected all 0", pdm_input_o, write_en_o, busy_o, full_o, count_o);
        end
        #2 reset_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_o !== 1'b0 || write_en_o !== 1'b0 || count_o !== 3'd0) begin
                errors++; $display("FAIL post_reset_start[%0d]: got busy=%b we=%b count=%0d expected 0 0 0", i, busy_o, write_en_o, count_o);
            end
            step();
        end
    endtask

    initial begin
        reset_i = 1'b1;
        load_i = 1'b0; clear_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        load_data_i = 5'h00; hold_period_i = 4'h0;
        step(); step();
        test_reset();
        reset_i = 1'b0;
        step();
        test_reset();
        test_load_fill();
        test_playback();
        test_hold_zero();
        test_stop_due();
        test_priority();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdm_sample_sequencer.md
Name: pdm_sample_sequencer

Overview:
- Sequencer that drives the load port of the 5-bit first-order PDM modulator.
- Stores a short table of 5-bit samples, loaded one at a time while idle.
- When started, replays the loaded samples cyclically, issuing one single-cycle write strobe per sample at a programmable interval.
- Sits between the chip pins or scan interface and the modulator; its outputs connect directly to the modulator's sample input and write-enable.

Parameters:
- DEPTH, 4, number of sample slots; power of two, at least 2.
- SAMPLE_W, 5, sample width; must match the modulator input width.
- HOLD_W, 4, width of the hold-period field.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- load  input  1  write load_data into the next free slot (accepted only in IDLE).
- load_data  input  SAMPLE_W  sample to store.
- clear  input  1  empty the table (accepted only in IDLE).
- start  input  1  begin playback (accepted only in IDLE).
- stop  input  1  end playback (accepted only in PLAY).
- hold_period  input  HOLD_W  cycles between strobes minus one; latched at start.
- pdm_input  output  SAMPLE_W  sample presented to the modulator; registered.
- write_en  output  1  one-cycle strobe marking pdm_input valid; registered.
- busy  output  1  high while in PLAY.
- full  output  1  table holds DEPTH samples.
- count  output  log2(DEPTH)+1  number of loaded samples, 0..DEPTH.

Behaviour:
- Reset values: pdm_input=0, write_en=0, busy=0, full=0, count=0, wr_ptr=0, rd_ptr=0, hold_cnt=0, state=IDLE. Reset mid-playback aborts immediately; no strobe is issued.
- States: IDLE and PLAY (plus MUTE if the optional feature is compiled in).
- IDLE, clear: sets count=0 and wr_ptr=0. Table contents are left stale.
- IDLE, load while count<DEPTH: writes slot[wr_ptr], increments wr_ptr and count. full=(count==DEPTH).
- IDLE, load while full: dropped; no change to table, count or pointers.
- IDLE, same-cycle priority: clear beats load; load beats start (start is ignored in a cycle with load or clear asserted).
- IDLE, start with count==0: ignored.
- IDLE, start with count>0 (edge t):
  - state=PLAY at t+1;
  - rd_ptr=0, hold_reg=hold_period, hold_cnt=hold_period;
  - the first strobe is issued in the same transition: at t+1, write_en=1 and pdm_input=slot[0].
- PLAY, each cycle:
  - if hold_cnt==0: next cycle write_en=1, pdm_input=slot[rd_ptr+1 wrapped at count], rd_ptr advances, hold_cnt reloads hold_reg;
  - else hold_cnt decrements and write_en=0.
  - Strobe spacing is exactly hold_reg+1 cycles. hold_period=0 gives a strobe every cycle.
  - Playback wraps from index count-1 back to 0; unloaded slots are never played.
- PLAY, ignored inputs: load, clear and start; changes on hold_period have no effect until the next start.
- PLAY, stop: next cycle state=IDLE, busy=0, write_en=0. pdm_input holds its last value. rd_ptr and the table are preserved; count is unchanged.
- Simultaneous stop and a due strobe: stop wins; no strobe is issued.
- busy is registered and equals (state!=IDLE).
- Pointer and count arithmetic is unsigned and wraps modulo DEPTH; count saturates at DEPTH.

Optional Feature:
- Macro: PDM_SEQ_MUTE_EN.
- Defined: stop in PLAY moves to MUTE instead of IDLE.
  - MUTE lasts exactly one cycle: write_en=1, pdm_input=0, busy=1.
  - The block then enters IDLE.
  - This leaves the modulator holding a zero sample, so its output idles low.
  - Reset during MUTE goes straight to reset values.
- Undefined: no MUTE state; stop behaves as described in Behaviour and pdm_input keeps its last sample.

Test Plan:
- Reset, then load 5'h03, 5'h1F, 5'h10 -> count=3, full=0; a further 5'h01 gives count=4, full=1; a fifth load is dropped, count stays 4.
- Load 3 samples, hold_period=2, start -> write_en on cycles t+1, t+4, t+7, t+10 carrying 03, 1F, 10, 03; busy=1 throughout.
- hold_period=0 with 2 samples 0A,15 -> write_en high every cycle, pdm_input alternates 0A,15.
- Stop during PLAY when a strobe is due -> no strobe, busy=0 next cycle, pdm_input unchanged. With PDM_SEQ_MUTE_EN: one strobe with pdm_input=0, then idle.
- Assert load+clear together in IDLE -> count=0. Assert start with count=0 -> stays IDLE, write_en never asserted.
- Assert reset asynchronously mid-PLAY between clock edges -> all outputs reset values immediately; a following start with count=0 does nothing.
